// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter
//   Shares the CPU's 8-bit tri-stated data bus between two requesters
//   (port 0 = CPU core, port 1 = I/O / DMA). Each granted transfer runs
//   IDLE -> SETUP -> ACCESS (WAIT_CYCLES+1 cycles) -> TURN, so the bus
//   driver and memory never contend. All outputs are registered.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   req0/we0/addr0/wdata0 port-0 request, direction (1=write), address, data
//   req1/we1/addr1/wdata1 port-1 request, direction, address, data
//   gnt0, gnt1            grant, SETUP through TURN of the port's transfer
//   done0, done1          one-cycle completion pulse in TURN
//   rdata                 data of the last completed read (held)
//   bus_addr, bus_wdata   latched address / write data towards memory
//   data_ena              bus driver enable (1 = drive, 0 = high-Z)
//   rd, wr                memory read / write strobes
//   bus_rdata             value sampled from the shared data bus
//   busy                  high in every state except IDLE
module data_bus_arbiter #(
    parameter int ADDR_W      = 13,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              we0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [7:0]        wdata0,
    input  logic              req1,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [7:0]        wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              done0,
    output logic              done1,
    output logic [7:0]        rdata,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [7:0]        bus_wdata,
    output logic              data_ena,
    output logic              rd,
    output logic              wr,
    input  logic [7:0]        bus_rdata,
    output logic              busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_TURN
    } state_t;

    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    generate
        if (WAIT_CYCLES < 0 || WAIT_CYCLES > 7) begin : g_bad_wait
            $error("data_bus_arbiter: WAIT_CYCLES must lie in 0..7");
        end
    endgenerate

    state_t     r_state;
    logic       r_last_gnt;   // port granted most recently (1 after reset)
    logic       r_we;         // latched direction of the current transfer
    logic [2:0] r_wait;       // remaining extra ACCESS cycles

    logic w_any_req;
    logic w_pick1;

    assign w_any_req = req0 | req1;
    // Port 1 wins when it is alone, or when both request and port 0 was last.
    assign w_pick1   = req1 & (~req0 | ~r_last_gnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_last_gnt <= 1'b1;
            r_we       <= 1'b0;
            r_wait     <= 3'd0;
            gnt0       <= 1'b0;
            gnt1       <= 1'b0;
            done0      <= 1'b0;
            done1      <= 1'b0;
            rd         <= 1'b0;
            wr         <= 1'b0;
            data_ena   <= 1'b0;
            busy       <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= 8'd0;
            rdata      <= 8'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state    <= S_SETUP;
                        busy       <= 1'b1;
                        r_last_gnt <= w_pick1;
                        gnt0       <= ~w_pick1;
                        gnt1       <= w_pick1;
                        if (w_pick1) begin
                            bus_addr  <= addr1;
                            bus_wdata <= wdata1;
                            r_we      <= we1;
                        end else begin
                            bus_addr  <= addr0;
                            bus_wdata <= wdata0;
                            r_we      <= we0;
                        end
                    end
                end

                S_SETUP: begin
                    // Address has had one full cycle to settle; open the strobe.
                    r_state  <= S_ACCESS;
                    r_wait   <= WAIT_INIT;
                    wr       <= r_we;
                    data_ena <= r_we;
                    rd       <= ~r_we;
                end

                S_ACCESS: begin
                    if (r_wait == 3'd0) begin
                        r_state  <= S_TURN;
                        rd       <= 1'b0;
                        wr       <= 1'b0;
                        data_ena <= 1'b0;
                        done0    <= gnt0;
                        done1    <= gnt1;
                        if (!r_we) begin
                            rdata <= bus_rdata;
                        end
                    end else begin
                        r_wait <= r_wait - 3'd1;
                    end
                end

                S_TURN: begin
                    // Bus released for one cycle before anyone else may drive it.
                    r_state <= S_IDLE;
                    gnt0    <= 1'b0;
                    gnt1    <= 1'b0;
                    done0   <= 1'b0;
                    done1   <= 1'b0;
                    busy    <= 1'b0;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// tb_data_bus_arbiter
//   Scoreboard bench for data_bus_arbiter. Expected completions (port and,
//   for reads, the data) are queued when a request is raised and compared
//   when the DUT pulses done. Extra instances cover WAIT_CYCLES = 0 and 7.
module tb_data_bus_arbiter;

    localparam int ADDR_W = 13;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              req0, we0, req1, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [7:0]        wdata0, wdata1, bus_rdata;
    logic              gnt0, gnt1, done0, done1, data_ena, rd, wr, busy;
    logic [7:0]        rdata, bus_wdata;
    logic [ADDR_W-1:0] bus_addr;

    logic              rq_w0, rq_w7;
    logic              g0_w0, g1_w0, d0_w0, d1_w0, ena_w0, rd_w0, wr_w0, busy_w0;
    logic              g0_w7, g1_w7, d0_w7, d1_w7, ena_w7, rd_w7, wr_w7, busy_w7;
    logic [7:0]        rdata_w0, wdata_w0, rdata_w7, wdata_w7;
    logic [ADDR_W-1:0] addr_w0, addr_w7;

    data_bus_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(1)) u_dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .data_ena(data_ena), .rd(rd), .wr(wr), .bus_rdata(bus_rdata), .busy(busy)
    );

    data_bus_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(0)) u_dut_w0 (
        .clk(clk), .rst_n(rst_n),
        .req0(rq_w0), .we0(1'b1), .addr0(addr0), .wdata0(wdata0),
        .req1(1'b0), .we1(1'b0), .addr1(addr1), .wdata1(wdata1),
        .gnt0(g0_w0), .gnt1(g1_w0), .done0(d0_w0), .done1(d1_w0),
        .rdata(rdata_w0), .bus_addr(addr_w0), .bus_wdata(wdata_w0),
        .data_ena(ena_w0), .rd(rd_w0), .wr(wr_w0), .bus_rdata(bus_rdata), .busy(busy_w0)
    );

    data_bus_arbiter #(.ADDR_W(ADDR_W), .WAIT_CYCLES(7)) u_dut_w7 (
        .clk(clk), .rst_n(rst_n),
        .req0(rq_w7), .we0(1'b1), .addr0(addr0), .wdata0(wdata0),
        .req1(1'b0), .we1(1'b0), .addr1(addr1), .wdata1(wdata1),
        .gnt0(g0_w7), .gnt1(g1_w7), .done0(d0_w7), .done1(d1_w7),
        .rdata(rdata_w7), .bus_addr(addr_w7), .bus_wdata(wdata_w7),
        .data_ena(ena_w7), .rd(rd_w7), .wr(wr_w7), .bus_rdata(bus_rdata), .busy(busy_w7)
    );

    typedef struct packed {
        logic       port;
        logic       is_rd;
        logic [7:0] data;
    } exp_t;

    exp_t sb_q[$];
    int   done_t[$];
    int   n_chk    = 0;
    int   n_fail   = 0;
    int   n_cyc    = 0;
    int   viol_gnt = 0;
    int   viol_ena = 0;
    int   viol_dn  = 0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic bit pending(bit p);
        foreach (sb_q[i]) if (sb_q[i].port == p) return 1'b1;
        return 1'b0;
    endfunction

    // Advance one clock, sample #1 after the edge, track invariants and
    // retire a scoreboard entry on every done pulse.
    task automatic step();
        exp_t e;
        @(posedge clk);
        #1;
        n_cyc++;
        if (gnt0 && gnt1) viol_gnt++;
        if (data_ena && rd) viol_ena++;
        if (done0 && done1) viol_dn++;
        if (g1_w0 || rd_w0 || d1_w0 || g1_w7 || rd_w7 || d1_w7) viol_gnt++;
        if (done0 || done1) begin
            chk("sb_expected_done", 32'(sb_q.size() != 0), 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("done_port", 32'(done1), 32'(e.port));
                if (e.is_rd) chk("rdata", 32'(rdata), 32'(e.data));
            end
        end
    endtask

    // Run until every queued transfer completed and the DUT is idle again;
    // a requester drops req once it has nothing left queued.
    task automatic drain(int budget);
        int n = 0;
        while ((sb_q.size() != 0 || busy) && n < budget) begin
            step();
            n++;
            if (done0 || done1) done_t.push_back(n_cyc);
            if (done0 && !pending(1'b0)) req0 = 1'b0;
            if (done1 && !pending(1'b1)) req1 = 1'b0;
        end
        chk("drain_complete", 32'(sb_q.size()), 32'd0);
    endtask

    task automatic run_wait(bit sel7, int exp_acc, int exp_busy);
        int  nacc = 0;
        int  nbsy = 0;
        int  n    = 0;
        bit  seen = 1'b0;
        if (sel7) rq_w7 = 1'b1; else rq_w0 = 1'b1;
        do begin
            step();
            n++;
            if (sel7) begin
                nacc += int'(wr_w7 && ena_w7);
                nbsy += int'(busy_w7);
                if (d0_w7) begin
                    rq_w7 = 1'b0;
                    seen  = 1'b1;
                    chk("w7_addr", 32'(addr_w7), 32'h0AA);
                    chk("w7_wdata", 32'(wdata_w7), 32'h11);
                    chk("w7_gnt_in_turn", 32'(g0_w7), 32'd1);
                end
            end else begin
                nacc += int'(wr_w0 && ena_w0);
                nbsy += int'(busy_w0);
                if (d0_w0) begin
                    rq_w0 = 1'b0;
                    seen  = 1'b1;
                    chk("w0_addr", 32'(addr_w0), 32'h0AA);
                    chk("w0_wdata", 32'(wdata_w0), 32'h11);
                    chk("w0_gnt_in_turn", 32'(g0_w0), 32'd1);
                end
            end
        end while (!(seen && !(sel7 ? busy_w7 : busy_w0)) && n < 40);
        chk(sel7 ? "w7_done_seen" : "w0_done_seen", 32'(seen), 32'd1);
        chk(sel7 ? "w7_access_cycles" : "w0_access_cycles", 32'(nacc), 32'(exp_acc));
        chk(sel7 ? "w7_busy_cycles" : "w0_busy_cycles", 32'(nbsy), 32'(exp_busy));
        chk(sel7 ? "w7_rdata_untouched" : "w0_rdata_untouched",
            32'(sel7 ? rdata_w7 : rdata_w0), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = 8'd0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = 8'd0;
        bus_rdata = 8'd0; rq_w0 = 1'b0; rq_w7 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_ctrl", 32'({gnt0, gnt1, done0, done1, rd, wr, data_ena, busy}), 32'd0);
        chk("reset_bus_addr", 32'(bus_addr), 32'd0);
        chk("reset_wdata_rdata", 32'({bus_wdata, rdata}), 32'd0);
        rst_n = 1'b1;

        // Single write on port 0
        step();
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0A5; wdata0 = 8'h3C;
        sb_q.push_back('{port: 1'b0, is_rd: 1'b0, data: 8'h00});
        step();
        chk("t1_gnt0_setup", 32'({gnt0, gnt1, busy}), 32'b101);
        chk("t1_setup_addr", 32'(bus_addr), 32'h0A5);
        chk("t1_setup_strobes", 32'({wr, data_ena, rd}), 32'd0);
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t1_access_strobes", 32'({wr, data_ena, rd}), 32'b110);
            chk("t1_access_wdata", 32'(bus_wdata), 32'h3C);
        end
        step();
        chk("t1_turn", 32'({done0, gnt0, wr, data_ena, busy}), 32'b11001);
        req0 = 1'b0;
        step();
        chk("t1_idle", 32'({busy, gnt0, done0}), 32'd0);

        // Single read on port 1
        req1 = 1'b1; we1 = 1'b0; addr1 = 13'h1FF; wdata1 = 8'hEE;
        sb_q.push_back('{port: 1'b1, is_rd: 1'b1, data: 8'h5A});
        step();
        chk("t2_setup", 32'({gnt1, gnt0, rd}), 32'b100);
        chk("t2_setup_addr", 32'(bus_addr), 32'h1FF);
        bus_rdata = 8'h5A;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_access_strobes", 32'({rd, data_ena, wr}), 32'b100);
        end
        step();
        chk("t2_turn", 32'({done1, done0, rd, gnt1}), 32'b1001);
        req1 = 1'b0;
        bus_rdata = 8'hFF;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("t2_rdata_held", 32'(rdata), 32'h5A);
            chk("t2_done_single", 32'(done1), 32'd0);
        end

        // Both ports from reset: grant order 0,1,0,1, 5 cycles per transfer
        #2 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        chk("t3_reset_rdata", 32'({rdata, busy}), 32'd0);
        bus_rdata = 8'hA7;
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h010; wdata0 = 8'h21;
        req1 = 1'b1; we1 = 1'b0; addr1 = 13'h020;
        for (int i = 0; i < 2; i++) begin
            sb_q.push_back('{port: 1'b0, is_rd: 1'b0, data: 8'h00});
            sb_q.push_back('{port: 1'b1, is_rd: 1'b1, data: 8'hA7});
        end
        done_t.delete();
        t0 = n_cyc;
        drain(60);
        chk("t3_done_count", 32'(done_t.size()), 32'd4);
        if (done_t.size() > 0) chk("t3_first_latency", 32'(done_t[0] - t0), 32'd4);
        for (int i = 1; i < done_t.size(); i++)
            chk("t3_transfer_period", 32'(done_t[i] - done_t[i-1]), 32'd5);

        // Address change after grant is ignored
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h123; wdata0 = 8'h81;
        sb_q.push_back('{port: 1'b0, is_rd: 1'b0, data: 8'h00});
        step();
        chk("t4_setup_addr", 32'({gnt0, bus_addr}), 32'({1'b1, 13'h123}));
        addr0 = 13'h000; wdata0 = 8'h00; we0 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("t4_addr_latched", 32'(bus_addr), 32'h123);
            if (i < 2) chk("t4_write_latched", 32'({wr, rd, bus_wdata}), 32'({2'b10, 8'h81}));
        end
        req0 = 1'b0;
        step();

        // Reset during ACCESS of a write; port 0 must win afterwards
        req0 = 1'b1; we0 = 1'b1; addr0 = 13'h0F0; wdata0 = 8'h55;
        step();
        chk("t5_setup_gnt0", 32'(gnt0), 32'd1);
        step();
        chk("t5_access_wr", 32'({wr, data_ena}), 32'b11);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_async_release", 32'({data_ena, wr, gnt0, busy}), 32'd0);
        req1 = 1'b1; we1 = 1'b1; addr1 = 13'h0F1; wdata1 = 8'h66;
        step();
        chk("t5_no_done", 32'({done0, done1}), 32'd0);
        rst_n = 1'b1;
        sb_q.push_back('{port: 1'b0, is_rd: 1'b0, data: 8'h00});
        sb_q.push_back('{port: 1'b1, is_rd: 1'b0, data: 8'h00});
        step();
        chk("t5_port0_wins", 32'({gnt0, gnt1}), 32'b10);
        drain(40);

        // WAIT_CYCLES = 0 and 7 builds
        addr0 = 13'h0AA; wdata0 = 8'h11;
        run_wait(1'b0, 1, 3);
        run_wait(1'b1, 8, 10);

        chk("gnt_exclusive", 32'(viol_gnt), 32'd0);
        chk("ena_rd_exclusive", 32'(viol_ena), 32'd0);
        chk("done_exclusive", 32'(viol_dn), 32'd0);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
